pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 19 +
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: default stage widths, the NOP control word
// and the stall-counter width.
package pipe_stage_reg_pkg;

  localparam int CTRL_W_DEF  = 13;
  localparam int DATA_W_DEF  = 16;
  localparam int NUM_SRC_DEF = 2;
  localparam int ADDR_W_DEF  = 3;
  localparam int NUM_DST_DEF = 2;
  localparam int FUNC_W_DEF  = 4;

  localparam int STALL_W = 16;

  // All-zero control bundle presented downstream as a bubble.
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module pipe_sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int W = STALL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding at the maximum once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Single pipeline register stage with valid/ready handshake, flush and a
// back-pressure counter. Defining PIPE_STAGE_SKID_EN adds a skid entry so
// in_ready comes from a register instead of out_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_DST = NUM_DST_DEF,
  parameter int FUNC_W  = FUNC_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [NUM_DST*ADDR_W-1:0] in_waddr,
  input  logic [FUNC_W-1:0]         in_func,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_SRC*DATA_W-1:0] out_data,
  output logic [NUM_DST*ADDR_W-1:0] out_waddr,
  output logic [FUNC_W-1:0]         out_func,
  output logic [STALL_W-1:0]        stall_cnt
);

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic                      skid_valid;
  logic [CTRL_W-1:0]         skid_ctrl;
  logic [NUM_SRC*DATA_W-1:0] skid_data;
  logic [NUM_DST*ADDR_W-1:0] skid_waddr;
  logic [FUNC_W-1:0]         skid_func;

  // Ready depends only on skid occupancy (a register) and flush.
  assign in_ready = !skid_valid && !flush;

  // Output refills from the skid entry first so ordering is preserved;
  // an input arriving while the output is stalled parks in the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ctrl   <= NOP;
      out_data   <= '0;
      out_waddr  <= '0;
      out_func   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= NOP;
      skid_data  <= '0;
      skid_waddr <= '0;
      skid_func  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= NOP;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_xfer) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        out_waddr  <= skid_waddr;
        out_func   <= skid_func;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
        out_waddr <= in_waddr;
        out_func  <= in_func;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= NOP;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
      skid_waddr <= in_waddr;
      skid_func  <= in_func;
    end
  end
`else
  // Ready passes straight through from downstream when a slot will free up.
  assign in_ready = !flush && (!out_valid || out_ready);

  // Load on input transfer; drop to a NOP bubble when the entry leaves.
  // Data, address and function fields hold while no entry is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= NOP;
      out_data  <= '0;
      out_waddr <= '0;
      out_func  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= NOP;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
      out_waddr <= in_waddr;
      out_func  <= in_func;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
      out_ctrl  <= NOP;
    end
  end
`endif

  logic stall_en;
  assign stall_en = out_valid && !out_ready;

  pipe_sat_counter #(
    .W(STALL_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (stall_en),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + scoreboard bench for pipe_stage_reg (default or skid build).
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [12:0] ctrl;
    logic [31:0] data;
    logic [5:0]  waddr;
    logic [3:0]  func;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [12:0] in_ctrl, out_ctrl;
  logic [31:0] in_data, out_data;
  logic [5:0]  in_waddr, out_waddr;
  logic [3:0]  in_func, out_func;
  logic [15:0] stall_cnt;

  logic        p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [12:0] p_in_ctrl, p_out_ctrl;
  logic [95:0] p_in_data, p_out_data;
  logic [2:0]  p_in_waddr, p_out_waddr;
  logic [3:0]  p_in_func, p_out_func;
  logic [15:0] p_stall_cnt;

  int checks = 0;
  int failures = 0;

  ent_t q[$];
  ent_t last;
  logic [15:0] stall_exp;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_waddr(in_waddr), .in_func(in_func),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_waddr(out_waddr), .out_func(out_func),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.NUM_SRC(3), .DATA_W(32), .NUM_DST(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_ctrl(p_in_ctrl), .in_data(p_in_data), .in_waddr(p_in_waddr), .in_func(p_in_func),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_ctrl(p_out_ctrl), .out_data(p_out_data), .out_waddr(p_out_waddr), .out_func(p_out_func),
    .stall_cnt(p_stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input int c, input logic [31:0] d, input int w, input int f);
    ent_t e;
    e.ctrl  = 13'(c);
    e.data  = d;
    e.waddr = 6'(w);
    e.func  = 4'(f);
    return e;
  endfunction

  // One cycle: drive at negedge, check against the model, update the model
  // after the posedge from what the model says should have transferred.
  task automatic step(input bit v, input bit r, input bit f, input ent_t e);
    bit exp_rdy, ix, ox;
    int n;
    in_valid = v; out_ready = r; flush = f;
    in_ctrl = e.ctrl; in_data = e.data; in_waddr = e.waddr; in_func = e.func;
    #1;
    n = q.size();
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = !f && (n < 2);
`else
    exp_rdy = !f && ((n == 0) || r);
`endif
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("out_valid", 128'(out_valid), 128'(n != 0));
    if (n != 0) begin
      chk("out_entry", 128'({out_ctrl, out_data, out_waddr, out_func}), 128'(q[0]));
    end else begin
      chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
      chk("hold_fields", 128'({out_data, out_waddr, out_func}),
          128'({last.data, last.waddr, last.func}));
    end
    chk("stall_cnt", 128'(stall_cnt), 128'(stall_exp));
    ox = (n != 0) && r;
    ix = v && exp_rdy;
    @(posedge clk);
    if ((n != 0) && !r && (stall_exp != 16'hFFFF)) stall_exp++;
    if (f) begin
      q.delete();
    end else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(e);
    end
    if (q.size() != 0) last = q[0];
    @(negedge clk);
  endtask

  initial begin
    ent_t z;
    int total;
    z = '0;
    last = '0;
    stall_exp = '0;
    rst_n = 1'b0;
    flush = 0; in_valid = 0; out_ready = 0;
    in_ctrl = '0; in_data = '0; in_waddr = '0; in_func = '0;
    p_flush = 0; p_in_valid = 0; p_out_ready = 1;
    p_in_ctrl = '0; p_in_data = '0; p_in_waddr = '0; p_in_func = '0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'({out_data, out_waddr, out_func}), 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, one entry per cycle.
    step(1, 1, 0, mk(13'h0011, 32'h0002_0001, 6'h05, 4'h3));
    step(1, 1, 0, mk(13'h0022, 32'h0004_0003, 6'h2A, 4'hC));
    step(0, 1, 0, z);
    step(0, 1, 0, z);

    // Back-pressure for 5 cycles.
    step(1, 1, 0, mk(13'h0101, 32'hAAAA_5555, 6'h11, 4'h1));
    for (int i = 0; i < 5; i++) step(1, 0, 0, mk(13'h0202 + i, 32'hBBBB_0000 + i, 6'h22, 4'h2));
    chk("stall_after_5", 128'(stall_cnt), 128'(16'd5));
    step(0, 1, 0, z);
    step(0, 1, 0, z);
    step(0, 1, 0, z);

    // Flush with a held entry and a same-cycle incoming entry.
    step(1, 1, 0, mk(13'h0333, 32'hC0C0_C0C0, 6'h33, 4'h3));
    step(1, 0, 0, mk(13'h0444, 32'hD0D0_D0D0, 6'h04, 4'h4));
    step(1, 0, 1, mk(13'h0555, 32'hE0E0_E0E0, 6'h05, 4'h5));
    step(0, 1, 0, z);
    step(0, 1, 0, z);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 80; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 15) == 0),
           mk(int'($urandom_range(1, 8191)), $urandom, int'($urandom_range(0, 63)),
              int'($urandom_range(0, 15))));
    end

    // Asynchronous reset mid-stream.
    step(1, 0, 0, mk(13'h0666, 32'h1234_5678, 6'h06, 4'h6));
    step(1, 0, 0, mk(13'h0777, 32'h8765_4321, 6'h07, 4'h7));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_ctrl", 128'(out_ctrl), 128'(0));
    chk("mid_rst_fields", 128'({out_data, out_waddr, out_func}), 128'(0));
    chk("mid_rst_stall", 128'(stall_cnt), 128'(0));
    q.delete();
    last = '0;
    stall_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, mk(13'h0888, 32'h0F0F_0F0F, 6'h08, 4'h8));
    step(0, 1, 0, z);

    // Saturation of the stall counter.
    step(1, 1, 0, mk(13'h0999, 32'h5A5A_5A5A, 6'h09, 4'h9));
    in_valid = 0; out_ready = 0; flush = 0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    total = int'(stall_exp) + 70000;
    stall_exp = (total > 65535) ? 16'hFFFF : 16'(total);
    chk("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
    chk("stall_sat_model", 128'(stall_cnt), 128'(stall_exp));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_sat_hold", 128'(stall_cnt), 128'(16'hFFFF));
    step(0, 0, 0, z);
    step(0, 1, 0, z);
    step(0, 1, 0, z);

    // Wide-parameter instance: three 32-bit channels, one address channel.
    p_in_valid = 1;
    p_in_ctrl  = 13'h1ABC;
    p_in_data  = {32'hDEADBEEF, 32'h2222_2222, 32'h1111_1111};
    p_in_waddr = 3'h5;
    p_in_func  = 4'hA;
    #1;
    chk("p_in_ready", 128'(p_in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    p_in_valid = 0;
    chk("p_out_valid", 128'(p_out_valid), 128'(1));
    chk("p_ch2", 128'(p_out_data[95:64]), 128'(32'hDEADBEEF));
    chk("p_ch0", 128'(p_out_data[31:0]), 128'(32'h1111_1111));
    chk("p_ch1", 128'(p_out_data[63:32]), 128'(32'h2222_2222));
    chk("p_side", 128'({p_out_ctrl, p_out_waddr, p_out_func}), 128'({13'h1ABC, 3'h5, 4'hA}));
    @(posedge clk);
    @(negedge clk);
    chk("p_drained", 128'(p_out_valid), 128'(0));
    chk("p_stall", 128'(p_stall_cnt), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
